// File: rtl/definitions_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : definitions_pkg                                            |
// | Description : Shared type definitions, including the ALU operation enum. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package definitions_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_e;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_arbiter                                                |
// | Description : Shares one combinational ALU between N_REQ requesters via  |
// |               an issue register and a response register. Round-robin by  |
// |               default; define ALU_ARB_FIXED_PRIO_EN for fixed priority   |
// |               (lowest index wins).                                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_arbiter
  import definitions_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      i_req_valid,
  output logic [N_REQ-1:0]      o_req_ready,
  input  logic [N_REQ*XLEN-1:0] i_req_a,
  input  logic [N_REQ*XLEN-1:0] i_req_b,
  input  alu_e                  i_req_sel [N_REQ],
  output logic [N_REQ-1:0]      o_rsp_valid,
  input  logic [N_REQ-1:0]      i_rsp_ready,
  output logic [XLEN-1:0]       o_rsp_result,
  output logic [XLEN-1:0]       o_alu_a,
  output logic [XLEN-1:0]       o_alu_b,
  output alu_e                  o_alu_sel,
  input  logic [XLEN-1:0]       i_alu_result
);

  localparam int               c_idw = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] c_one = {{(N_REQ-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  logic [XLEN-1:0]  r_s1_a;
  logic [XLEN-1:0]  r_s1_b;
  alu_e             r_s1_sel;
  logic [c_idw-1:0] r_s1_id;
  logic             r_s2_valid;
  logic [XLEN-1:0]  r_s2_result;
  logic [c_idw-1:0] r_s2_id;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_accept;
  logic             w_gnt_vld;
  logic [c_idw-1:0] w_gnt_id;
  logic             w_take;

  assign w_s2_free = !r_s2_valid || i_rsp_ready[r_s2_id];
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_accept  = !r_s1_valid || w_s1_adv;
  // rst_n term keeps every req_ready low while reset is held.
  assign w_take    = rst_n && w_accept && w_gnt_vld;

  assign o_req_ready  = w_take ? (c_one << w_gnt_id) : '0;
  assign o_rsp_valid  = r_s2_valid ? (c_one << r_s2_id) : '0;
  assign o_rsp_result = r_s2_result;
  assign o_alu_a      = r_s1_a;
  assign o_alu_b      = r_s1_b;
  assign o_alu_sel    = r_s1_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[c_idw'(i)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = c_idw'(i);
      end
    end
  end
`else
  logic [c_idw-1:0] r_rr_ptr;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    // Scan farthest-first so the nearest valid index after r_rr_ptr wins.
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req_valid[c_idw'((int'(r_rr_ptr) + k) % N_REQ)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = c_idw'((int'(r_rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= c_idw'(N_REQ - 1);
    end else if (w_take) begin
      r_rr_ptr <= w_gnt_id;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_sel    <= ALU_ADD;
      r_s1_id     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_id     <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= i_alu_result;
        r_s2_id     <= r_s1_id;
      end else if (r_s2_valid && i_rsp_ready[r_s2_id]) begin
        r_s2_valid <= 1'b0;
      end

      // On a drain without refill the operand registers hold, so the ALU sees no toggling.
      if (w_take) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= i_req_a[w_gnt_id*XLEN +: XLEN];
        r_s1_b     <= i_req_b[w_gnt_id*XLEN +: XLEN];
        r_s1_sel   <= i_req_sel[w_gnt_id];
        r_s1_id    <= w_gnt_id;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_arbiter                                             |
// | Description : Scoreboard bench for alu_arbiter with a behavioural ALU.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;
  import definitions_pkg::*;

  localparam int N  = 2;
  localparam int XL = 32;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*XL-1:0] req_a;
  logic [N*XL-1:0] req_b;
  alu_e            req_sel [N];
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [XL-1:0]   rsp_result;
  logic [XL-1:0]   alu_a;
  logic [XL-1:0]   alu_b;
  alu_e            alu_sel;
  logic [XL-1:0]   alu_result;

  int              n_tot = 0;
  int              n_bad = 0;
  logic [XL+7:0]   sb_q [$];
  logic [XL+7:0]   mon_e;
  int              lastg;
  int              expg;
  int              k_op;
  logic            got;
  logic [XL-1:0]   bp_a [3];
  logic [XL-1:0]   bp_b [3];
  alu_e            bp_s [3];

  alu_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_req_sel    (req_sel),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_result (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [XL-1:0] alu_fn(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                           input alu_e s);
    case (s)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {31'd0, (a < b)};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_LUI:  return b;
      default:  return '0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i])
          sb_q.push_back({8'(i), alu_fn(req_a[i*XL +: XL], req_b[i*XL +: XL], req_sel[i])});
      end
      if (rsp_valid != '0) begin
        check("rsp_onehot", 64'($onehot(rsp_valid)), 64'd1);
        if ((rsp_valid & rsp_ready) != '0) begin
          check("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check("rsp_owner", 64'(rsp_valid), 64'd1 << mon_e[XL+7:XL]);
            check("rsp_data", 64'(rsp_result), 64'(mon_e[XL-1:0]));
          end
        end
      end
    end
  end

  task automatic run_one(input int id, input logic [XL-1:0] a, input logic [XL-1:0] b,
                         input alu_e sel, input logic [XL-1:0] exp);
    step();
    req_a[id*XL +: XL] = a;
    req_b[id*XL +: XL] = b;
    req_sel[id]        = sel;
    req_valid          = N'(1) << id;
    @(negedge clk);
    check("op_req_ready", 64'(req_ready), 64'd1 << id);
    step();
    req_valid = '0;
    @(negedge clk);
    check("op_rsp_early", 64'(rsp_valid), 64'd0);
    step();
    @(negedge clk);
    check("op_rsp_valid", 64'(rsp_valid), 64'd1 << id);
    check("op_rsp_result", 64'(rsp_result), 64'(exp));
    step();
    @(negedge clk);
    check("op_rsp_once", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid  = '0;
    rsp_ready  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sel[0] = ALU_ADD;
    req_sel[1] = ALU_ADD;
    #1 rst_n   = 1'b0;
    req_valid  = '1;
    repeat (2) step();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_sel", 64'(alu_sel), 64'(ALU_ADD));
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    rsp_ready = '1;

    run_one(0, 32'd5, 32'd3, ALU_SUB, 32'd2);

    // Both requesters valid every cycle; last grant was requester 0.
    lastg = 0;
    step();
    req_valid  = '1;
    req_sel[0] = ALU_ADD;
    req_sel[1] = ALU_ADD;
    for (int c = 0; c < 8; c++) begin
      req_a = {32'(200 + c), 32'(100 + c)};
      req_b = {32'(c * 3), 32'(c * 7 + 1)};
      @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
      expg = 0;
`else
      expg = (lastg + 1) % N;
`endif
      check("rr_grant", 64'(req_ready), 64'd1 << expg);
      lastg = expg;
      step();
    end
    req_valid = '0;
    repeat (3) step();
    check("rr_drain", 64'(sb_q.size()), 64'd0);

    // Backpressure: three ops from requester 0 with responses blocked.
    bp_a = '{32'h11, 32'h22, 32'h33};
    bp_b = '{32'h1, 32'h2, 32'h3};
    bp_s = '{ALU_ADD, ALU_SUB, ALU_XOR};
    rsp_ready  = '0;
    k_op       = 0;
    req_valid  = 2'b01;
    for (int c = 0; c < 4; c++) begin
      req_a[0 +: XL] = bp_a[k_op];
      req_b[0 +: XL] = bp_b[k_op];
      req_sel[0]     = bp_s[k_op];
      @(negedge clk);
      check("bp_ready", 64'(req_ready), (c < 2) ? 64'd1 : 64'd0);
      if (c >= 2) begin
        check("bp_alu_a", 64'(alu_a), 64'h22);
        check("bp_alu_b", 64'(alu_b), 64'h2);
        check("bp_alu_sel", 64'(alu_sel), 64'(ALU_SUB));
        check("bp_rsp_result", 64'(rsp_result), 64'h12);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      end
      if (req_ready[0]) k_op++;
      step();
    end
    rsp_ready = '1;
    got       = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1'b1;
      step();
    end
    check("bp_third_accepted", 64'(got), 64'd1);
    req_valid = '0;
    repeat (4) step();
    check("bp_drain", 64'(sb_q.size()), 64'd0);

    // Fill both stages (req1 then req0, leaving the pointer at 0), then reset.
    rsp_ready          = '0;
    req_a[XL +: XL]    = 32'd1;
    req_b[XL +: XL]    = 32'd4;
    req_sel[1]         = ALU_SLL;
    req_valid          = 2'b10;
    @(negedge clk);
    check("mf_ready1", 64'(req_ready), 64'h2);
    step();
    req_a[0 +: XL] = 32'd1;
    req_b[0 +: XL] = 32'd4;
    req_sel[0]     = ALU_SLL;
    req_valid      = 2'b01;
    @(negedge clk);
    check("mf_ready0", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("mf_s2_full", 64'(rsp_valid), 64'h2);
    check("mf_s2_data", 64'(rsp_result), 64'h10);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mf_rst_rsp", 64'(rsp_valid), 64'd0);
    step();
    rst_n     = 1'b1;
    rsp_ready = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mf_no_rsp", 64'(rsp_valid), 64'd0);
    end
    step();
    req_a     = {32'd7, 32'd8};
    req_b     = {32'd9, 32'd10};
    req_sel[0] = ALU_ADD;
    req_sel[1] = ALU_ADD;
    req_valid = '1;
    @(negedge clk);
    check("mf_first_grant", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    repeat (3) step();

    run_one(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1);
    run_one(0, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 32'd0);
    run_one(1, 32'hFFFF_FFFF, 32'h1234_5000, ALU_LUI, 32'h1234_5000);
    repeat (2) step();
    check("final_drain", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational execute ALU between N_REQ requesters, for example the integer execute path and the address-generation/branch-compare path.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Two-stage pipeline: issue register drives the ALU; response register captures the result.
- Round-robin arbitration by default.

Parameters:
N_REQ, 2, number of requesters (2..8).
XLEN, 32, operand/result width; must match the ALU (32).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  N_REQ  per-requester request valid.
req_ready  out  N_REQ  per-requester request accept; at most one bit high.
req_a  in  N_REQ*XLEN  packed operand A, requester i at [i*XLEN +: XLEN].
req_b  in  N_REQ*XLEN  packed operand B, same packing.
req_sel  in  N_REQ x alu_e  per-requester ALU operation (definitions_pkg::alu_e).
rsp_valid  out  N_REQ  one-hot response valid, bit = owner of the result.
rsp_ready  in  N_REQ  per-requester response accept.
rsp_result  out  XLEN  result; meaningful only while any rsp_valid bit is set.
alu_a  out  XLEN  to ALU operand a.
alu_b  out  XLEN  to ALU operand b.
alu_sel  out  alu_e  to ALU operation select.
alu_result  in  XLEN  from ALU result.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - s1_valid=0, s2_valid=0, rr_ptr=N_REQ-1 (requester 0 wins first).
  - alu_a=0, alu_b=0, alu_sel=ALU_ADD, rsp_result=0.
  - rsp_valid=0, req_ready=0.
  - In-flight operations are discarded; no response is ever produced for them.
- Stage 1 (issue reg): holds a, b, sel, id, s1_valid. alu_a/alu_b/alu_sel are driven directly from stage-1 registers (registered outputs, no combinational path from req_* to alu_*).
- Stage 2 (rsp reg): holds result, id, s2_valid. rsp_valid = s2_valid ? onehot(id) : 0.
- Handshakes:
  - s2_free = !s2_valid | rsp_ready[s2_id].
  - s1_adv = s1_valid & s2_free.
  - accept = !s1_valid | s1_adv.
- Grant: first set req_valid bit searching from rr_ptr+1 upward, modulo N_REQ.
  - req_ready[g]=1 only when accept and req_valid[g].
  - req_ready may depend combinationally on req_valid. Requesters must not make valid depend on ready.
- Clock edge:
  - If s1_adv: s2 <= {alu_result, s1_id, 1}.
  - Else if s2 consumed: s2_valid <= 0.
  - If a request is granted: s1 <= {req_a[g], req_b[g], req_sel[g], g, 1} and rr_ptr <= g.
  - Else if s1_adv: s1_valid <= 0; alu_* hold their last values (no toggling).
- Latency: request handshake at edge k gives rsp_valid high after edge k+1.
- Throughput: 1 op/cycle while the targeted rsp_ready is high.
- Backpressure:
  - s2 full and not consumed: s1 holds; ALU inputs stable; rsp_result stable.
  - If s1 is also full: all req_ready=0.
- Pointer update: rr_ptr changes only on a successful grant. No valid requests leaves the pointer unchanged.
- Ordering: responses are returned in acceptance order. Simultaneous s2 consumption and s1 advance in the same cycle is lossless.
- Arithmetic: the block never modifies operands or results; the ALU defines all semantics.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. rr_ptr is removed and starvation of higher indices is permitted.
- When undefined: round-robin as above.
- Reset, pipeline and handshake behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with req_valid=all ones -> req_ready=0, rsp_valid=0, alu_a=alu_b=0, alu_sel=ALU_ADD, rsp_result=0.
- Single op: requester 0, a=5, b=3, sel=ALU_SUB, rsp_ready=all ones -> req_ready[0]=1 in that cycle; rsp_valid=01 with rsp_result=2 after the following edge, exactly one cycle.
- Round-robin: N_REQ=2, both valid continuously, rsp_ready=11, ADD with distinct operands -> grants 0,1,0,1...; rsp_valid alternates 01,10 every cycle with correct sums. With ALU_ARB_FIXED_PRIO_EN -> always requester 0.
- Backpressure: rsp_ready=00 while issuing 3 ops -> 2 accepted, third sees req_ready=0; rsp_result and alu_* stable. Release rsp_ready -> results drain in acceptance order, then the third is accepted.
- Reset mid-flight: s1 and s2 both valid (SLL a=1, b=4), pulse rst_n low -> no response after release; first post-reset grant goes to requester 0.
- Pass-through: a=32'hFFFFFFFF, b=1: ALU_SLT -> rsp_result=1; ALU_SLTU -> 0; ALU_LUI with b=32'h12345000 -> 32'h12345000.
